// File: rtl/parse_matrix_ascii.sv
// ASCII matrix receiver: turns a UART RX byte stream of decimal numbers into a
// row-major packed matrix, element k at data_out[k*ELEM_W +: ELEM_W].
module parse_matrix_ascii #(
  parameter int ELEM_W  = 16,
  parameter int MAX_DIM = 5
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [2:0]                        width,
  input  logic [2:0]                        height,
  input  logic [7:0]                        din,
  input  logic                              din_valid,
  output logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] data_out,
  output logic                              busy,
  output logic                              done,
  output logic                              error
);

  localparam int NUM_ELEM = MAX_DIM * MAX_DIM;
  localparam int IDX_W    = $clog2(NUM_ELEM + 1);
  localparam int ACC_W    = ELEM_W + 4;
  localparam logic [2:0] MAX_D = 3'(MAX_DIM);

  typedef enum logic [2:0] {S_IDLE, S_SKIP, S_ACC, S_DONE, S_ERR} state_t;

  state_t                           state;
  logic [NUM_ELEM-1:0][ELEM_W-1:0]  mat;
  logic [ELEM_W-1:0]                acc;
  logic [IDX_W-1:0]                 idx;
  logic [2:0]                       ndig;
  logic [5:0]                       total;

  logic             is_dig, is_sep, dims_ok, commit, ovf, last;
  logic [3:0]       dval;
  logic [ACC_W-1:0] acc_nx;
  logic [IDX_W-1:0] idx_inc;
  logic [5:0]       total_nx;

  assign data_out = mat;

  always_comb begin
    is_dig   = (din >= 8'h30) && (din <= 8'h39);
    is_sep   = (din == 8'h20) || (din == 8'h09) || (din == 8'h0D) || (din == 8'h0A);
    dval     = 4'(din - 8'h30);
    // Wide intermediate so an oversize value is caught rather than wrapped.
    acc_nx   = {4'b0, acc} * ACC_W'(10) + {{ELEM_W{1'b0}}, dval};
    ovf      = (acc_nx > {4'b0, {ELEM_W{1'b1}}}) || (ndig == 3'd5);
    dims_ok  = (width != 3'd0) && (height != 3'd0) && (width <= MAX_D) && (height <= MAX_D);
    total_nx = {3'b0, width} * {3'b0, height};
    idx_inc  = idx + 1'b1;
    last     = (6'(idx_inc) == total);
    commit   = (state == S_ACC) && din_valid && is_sep;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      mat   <= '0;
      acc   <= '0;
      idx   <= '0;
      ndig  <= '0;
      total <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      error <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_ELEM; k++)
        if (commit && idx == IDX_W'(k)) mat[k] <= acc;

      case (state)
        S_IDLE: begin
          done  <= 1'b0;
          error <= 1'b0;
          if (start) begin
            mat   <= '0;
            idx   <= '0;
            acc   <= '0;
            ndig  <= '0;
            total <= total_nx;
            if (dims_ok) begin
              state <= S_SKIP;
              busy  <= 1'b1;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
        end
        S_SKIP: if (din_valid) begin
          if (is_dig) begin
            acc   <= ELEM_W'(dval);
            ndig  <= 3'd1;
            state <= S_ACC;
          end else if (!is_sep) begin
            state <= S_ERR;
            busy  <= 1'b0;
            error <= 1'b1;
          end
        end
        S_ACC: if (din_valid) begin
          if (is_dig && !ovf) begin
            acc  <= acc_nx[ELEM_W-1:0];
            ndig <= ndig + 3'd1;
          end else if (is_sep) begin
            idx  <= idx_inc;
            acc  <= '0;
            ndig <= '0;
            if (last) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= S_SKIP;
            end
          end else begin
            // Unfinished number is dropped; only committed elements survive.
            state <= S_ERR;
            busy  <= 1'b0;
            error <= 1'b1;
          end
        end
        S_DONE: if (!start) begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        S_ERR: if (!start) begin
          state <= S_IDLE;
          error <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parse_matrix_ascii.sv
// Scoreboarded bench for parse_matrix_ascii: expected elements are queued as
// numbers are sent and popped against data_out when the parse finishes.
module tb_parse_matrix_ascii;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   width = '0;
  logic [2:0]   height = '0;
  logic [7:0]   din = '0;
  logic         din_valid = 1'b0;
  logic [399:0] data_out;
  logic         busy, done, error;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  parse_matrix_ascii dut (
    .clk(clk), .rst_n(rst_n), .start(start), .width(width), .height(height),
    .din(din), .din_valid(din_valid), .data_out(data_out),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; new inputs settle 1ns after the edge.
  task automatic put(input logic v, input logic [7:0] b);
    @(posedge clk); #1;
    din_valid = v;
    din = b;
  endtask

  // Sometimes precede a byte with an invalid cycle carrying junk that would
  // cause an error if it were consumed.
  task automatic send_byte(input logic [7:0] b);
    if ($urandom_range(0, 2) == 0) put(1'b0, 8'h78);
    put(1'b1, b);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic flush();
    put(1'b0, 8'h00);
  endtask

  task automatic begin_parse(input logic [2:0] w, input logic [2:0] h);
    @(posedge clk); #1;
    width = w; height = h; start = 1'b1;
  endtask

  task automatic end_parse();
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  // Pop every queued element and compare, then check that the rest is zero.
  task automatic drain(input string tag);
    int n;
    logic [399:0] rest;
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      logic [15:0] e;
      e = exp_q.pop_front();
      chk($sformatf("%s_e%0d", tag, k), {16'h0, data_out[k*16 +: 16]}, {16'h0, e});
    end
    rest = data_out >> (n * 16);
    chk({tag, "_rest0"}, {31'h0, rest == '0}, 32'd1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int c = 0;
    while (!done && !error && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    chk({tag, "_done"}, {30'h0, done, error}, 32'b10);
  endtask

  initial begin
    #2;
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_done", {31'h0, done}, 0);
    chk("rst_err", {31'h0, error}, 0);
    chk("rst_data", {31'h0, data_out == '0}, 1);
    @(posedge clk); #1 rst_n = 1'b1;

    // 2x2 with mixed separators
    begin_parse(3'd2, 3'd2);
    @(posedge clk); #1;
    chk("t1_busy", {31'h0, busy}, 1);
    send_str("1\t23\r\n456\t7890\r\n");
    exp_q.push_back(16'd1); exp_q.push_back(16'd23);
    exp_q.push_back(16'd456); exp_q.push_back(16'd7890);
    flush();
    wait_done("t1", 10);
    drain("t1");
    end_parse();
    chk("t1_idle", {30'h0, done, error}, 0);

    // 5x5, values 0..24; done lands exactly with the 25th separator
    begin_parse(3'd5, 3'd5);
    @(posedge clk); #1;
    chk("t2_busy", {31'h0, busy}, 1);
    for (int v = 0; v < 25; v++) begin
      send_str($sformatf("%0d", v));
      exp_q.push_back(16'(v));
      if (v == 24) chk("t2_busy_pre", {30'h0, busy, done}, 32'b10);
      send_byte(8'h20);
    end
    flush();
    chk("t2_edge", {30'h0, busy, done}, 32'b01);
    drain("t2");
    end_parse();

    // 1x1 overflow, then max value
    begin_parse(3'd1, 3'd1);
    send_str("65536 ");
    flush();
    chk("t3_err", {30'h0, done, error}, 32'b01);
    chk("t3_data", {31'h0, data_out == '0}, 1);
    end_parse();
    begin_parse(3'd1, 3'd1);
    send_str("65535 ");
    exp_q.push_back(16'hFFFF);
    flush();
    wait_done("t3b", 5);
    drain("t3b");
    end_parse();

    // leading zeros count toward the digit limit
    begin_parse(3'd2, 3'd1);
    send_str("007 000001 ");
    flush();
    chk("t3c_err", {30'h0, done, error}, 32'b01);
    chk("t3c_e0", {16'h0, data_out[15:0]}, 7);
    end_parse();

    // bad byte mid-number, then restart
    begin_parse(3'd2, 3'd1);
    send_str("12x");
    flush();
    chk("t4_err", {31'h0, error}, 1);
    chk("t4_data", {31'h0, data_out == '0}, 1);
    end_parse();
    chk("t4_idle", {31'h0, error}, 0);
    begin_parse(3'd2, 3'd1);
    send_str("3 4 ");
    flush();
    wait_done("t4b", 5);
    chk("t4b_word", data_out[31:0], 32'h0004_0003);
    end_parse();

    // illegal dimensions
    begin_parse(3'd0, 3'd3);
    @(posedge clk); #1;
    chk("t5_w0", {30'h0, busy, error}, 32'b01);
    end_parse();
    begin_parse(3'd6, 3'd1);
    @(posedge clk); #1;
    chk("t5_w6", {30'h0, busy, error}, 32'b01);
    end_parse();

    // async reset mid-number
    begin_parse(3'd3, 3'd1);
    send_str("10 20 3");
    flush();
    chk("t6_pre", {16'h0, data_out[31:16]}, 20);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst", {29'h0, busy, done, error}, 0);
    chk("t6_data", {31'h0, data_out == '0}, 1);
    start = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    begin_parse(3'd1, 3'd1);
    send_str("9 ");
    exp_q.push_back(16'd9);
    flush();
    wait_done("t6b", 5);
    drain("t6b");
    end_parse();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
